// File: rtl/argmax_pkg.sv
// Shared defaults and types for the argmax classifier.
// ARGMAX_RELU_EN clamps negative scores to zero before they are compared.
package argmax_pkg;
  localparam int N_CLASS_DEF = 10;
  localparam int DW_DEF = 22;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;
endpackage

// File: rtl/argmax_cmp.sv
// Score conditioning and strict-greater compare against the running best.
// ARGMAX_RELU_EN clamps negative scores to zero.
module argmax_cmp
  import argmax_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic signed [DW-1:0] din,
  input  logic signed [DW-1:0] best,
  input  logic                 first,
  output logic                 take,
  output logic signed [DW-1:0] score
);
`ifdef ARGMAX_RELU_EN
  assign score = din[DW-1] ? '0 : din;
`else
  assign score = din;
`endif

  // Strict compare keeps the lowest index on ties.
  assign take = first || (score > best);
endmodule

// File: rtl/argmax_classifier.sv
// Streams N_CLASS signed scores and reports the index of the largest.
// Build with ARGMAX_RELU_EN to clamp negative scores to zero.
module argmax_classifier
  import argmax_pkg::*;
#(
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     digit,
  output logic signed [DW-1:0] max_score
);
  localparam int CW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic signed [DW-1:0]  best;
  logic [IDX_W-1:0]      best_idx;
  logic signed [DW-1:0]  score;
  logic                  take;
  logic                  last;

  assign last = (cnt == CW'(N_CLASS - 1));

  argmax_cmp #(.DW(DW)) u_cmp (
    .din   (din),
    .best  (best),
    .first (cnt == '0),
    .take  (take),
    .score (score)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      best      <= '0;
      best_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      digit     <= '0;
      max_score <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (start) begin
            cnt <= '0;
          end else if (din_valid) begin
            if (take) begin
              best     <= score;
              best_idx <= IDX_W'(cnt);
            end
            // Results are registered here so they are visible in DONE.
            if (last) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              digit     <= take ? IDX_W'(cnt) : best_idx;
              max_score <= take ? score : best;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state <= SCAN;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier using directed score vectors.
// Expected results are queued at issue and checked when done pulses.
module tb_argmax_classifier;
  localparam int DW = 22;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic signed [DW-1:0] din;
  logic                 din_valid;
  logic                 busy;
  logic                 done;
  logic [3:0]           digit;
  logic signed [DW-1:0] max_score;

  typedef struct {
    logic [3:0]           d;
    logic signed [DW-1:0] s;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic signed [DW-1:0] sc[10];
  int gp[10];

  argmax_classifier dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .busy      (busy),
    .done      (done),
    .digit     (digit),
    .max_score (max_score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("digit", digit, e.d);
        check("max_score", max_score, e.s);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic feed(input logic signed [DW-1:0] v, input int gap);
    din_valid = 1'b0;
    repeat (gap) tick();
    din = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // Feeds sc[]/gp[]; leaves the bench in the DONE cycle.
  task automatic run_scan(input bit do_st, input logic [3:0] ed,
                          input logic signed [DW-1:0] es);
    exp_t e;
    e.d = ed;
    e.s = es;
    exp_q.push_back(e);
    if (do_st) do_start();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) check("done_early", done, 0);
      feed(sc[i], gp[i]);
    end
    check("done_latency", done, 1);
    check("busy_in_done", busy, 0);
  endtask

  task automatic settle();
    tick();
    check("done_one_cycle", done, 0);
    repeat (2) tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    din = '0;
    din_valid = 1'b0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_digit", digit, 0);
    check("rst_max", max_score, 0);
    rst = 1'b0;
    tick();

    // Tie at index 4 keeps index 1.
    sc = '{5, 9, 3, -2, 9, 1, 0, 7, 8, 2};
    gp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_scan(1, 4'd1, 22'sd9);
    settle();

    sc = '{-7, -3, -9, -4, -5, -6, -8, -10, -11, -12};
`ifdef ARGMAX_RELU_EN
    run_scan(1, 4'd0, 22'sd0);
`else
    run_scan(1, 4'd1, -22'sd3);
`endif
    settle();

    // Stray din_valid in IDLE, then gapped samples.
    for (int i = 0; i < 3; i++) begin
      din = 22'sd1000;
      din_valid = 1'b1;
      tick();
      check("idle_busy", busy, 0);
    end
    din_valid = 1'b0;
    sc = '{5, 9, 3, -2, 9, 1, 0, 7, 8, 2};
    gp = '{1, 0, 3, 2, 0, 1, 3, 0, 2, 1};
    run_scan(1, 4'd1, 22'sd9);
    settle();

    // Restart mid-scan; the sample offered with the restart is dropped.
    do_start();
    for (int i = 0; i < 4; i++) feed(22'sd2000000, 0);
    start = 1'b1;
    din = 22'sd2097151;
    din_valid = 1'b1;
    tick();
    start = 1'b0;
    din_valid = 1'b0;
    check("busy_restart", busy, 1);
    sc = '{100, -50, 3000, 2097150, 0, -2097152, 2097151, 2097151, 5, 1};
    gp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_scan(0, 4'd6, 22'sd2097151);
    settle();

    // Reset mid-scan clears outputs and suppresses done.
    do_start();
    for (int i = 0; i < 5; i++) feed(22'sd50, 0);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_digit", digit, 0);
    check("midrst_max", max_score, 0);
    check("midrst_done", done, 0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    sc = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    run_scan(1, 4'd5, 22'sd9);
    settle();

    // Start issued in the DONE cycle chains straight into SCAN.
    sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_scan(1, 4'd0, 22'sd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_chain", busy, 1);
    sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    run_scan(0, 4'd9, 22'sd10);
    settle();

    repeat (3) tick();
    check("pending_results", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
